// File: rtl/por_reset_sequencer.sv
// por_reset_sequencer
//   Digital power-on-reset sequencer behind the analog POR cells. Each raw
//   POR_N input is synchronised, the results are ANDed into por_ok, and
//   por_ok must stay high for FILTER_CYCLES before the domain resets are
//   released one by one, STAGE_DELAY cycles apart. A POR drop or a software
//   request re-asserts every domain reset at once.
//
//   Parameters: NUM_POR (>=1), NUM_DOMAINS (>=1), SYNC_STAGES (>=2),
//               FILTER_CYCLES (>=1), STAGE_DELAY (>=1).
//
//   Ports:
//     CLK_I          in   free-running clock
//     RST_I          in   asynchronous active-high reset
//     POR_N_I        in   [NUM_POR]     raw asynchronous POR, active-low
//     SW_RST_REQ_I   in   single-cycle synchronous software reset request
//     RST_N_O        out  [NUM_DOMAINS] domain resets, bit k released k-th
//     READY_O        out  high once every domain is released
//     STATE_O        out  [2] ASSERT=0, FILTER=1, RELEASE=2, RUN=3
//     BROWNOUT_O     out  one-cycle pulse on POR loss in RELEASE/RUN
//     BROWNOUT_CNT_O out  [8] saturating brown-out count (optional)
//
//   Build option: define POR_SEQ_BROWNOUT_CNT_EN to add BROWNOUT_CNT_O.
//   All outputs are registered.

// Per-input synchroniser; resets to 0 so por_ok starts low.
module por_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];
endmodule

module por_reset_sequencer #(
    parameter int NUM_POR       = 2,
    parameter int NUM_DOMAINS   = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int STAGE_DELAY   = 8
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [NUM_POR-1:0]     POR_N_I,
    input  logic                   SW_RST_REQ_I,
    output logic [NUM_DOMAINS-1:0] RST_N_O,
    output logic                   READY_O,
    output logic [1:0]             STATE_O,
    output logic                   BROWNOUT_O
`ifdef POR_SEQ_BROWNOUT_CNT_EN
    ,
    output logic [7:0]             BROWNOUT_CNT_O
`endif
);
    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_FILTER  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    // One counter serves both the filter window and the stagger delay.
    localparam int CNT_MAX = (FILTER_CYCLES > STAGE_DELAY) ? FILTER_CYCLES : STAGE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

    logic [NUM_POR-1:0]     por_sync_q;
    logic                   por_ok;
    logic [1:0]             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_DOMAINS-1:0] rst_n_q;
    logic [NUM_DOMAINS-1:0] rst_n_nxt;
    logic                   ready_q;
    logic                   brownout_q;
    logic                   in_seq;
    logic                   brownout_set;

    for (genvar g = 0; g < NUM_POR; g++) begin : g_sync
        por_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk (CLK_I),
            .rst (RST_I),
            .d   (POR_N_I[g]),
            .q   (por_sync_q[g])
        );
    end

    assign por_ok       = &por_sync_q;
    assign in_seq       = (state_q == ST_RELEASE) || (state_q == ST_RUN);
    // POR loss wins over a simultaneous software request, so the pulse
    // depends only on por_ok and the current state.
    assign brownout_set = !por_ok && in_seq;
    // Releases fill in from bit 0 upward, so bits can never release out of order.
    assign rst_n_nxt    = (rst_n_q << 1) | DOM_ONE;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            rst_n_q    <= '0;
            ready_q    <= 1'b0;
            brownout_q <= 1'b0;
        end else begin
            brownout_q <= brownout_set;
            if (!por_ok || (SW_RST_REQ_I && in_seq)) begin
                // Re-assertion is always all domains together.
                state_q <= ST_ASSERT;
                cnt_q   <= '0;
                rst_n_q <= '0;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ASSERT: begin
                        // Software requests are ignored here.
                        state_q <= ST_FILTER;
                        cnt_q   <= '0;
                    end
                    ST_FILTER: begin
                        if (SW_RST_REQ_I) begin
                            cnt_q <= '0;
                        end else if (cnt_q == FILT_LAST) begin
                            cnt_q   <= '0;
                            rst_n_q <= DOM_ONE;
                            if (NUM_DOMAINS == 1) begin
                                state_q <= ST_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_RELEASE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt_q == STAGE_LAST) begin
                            cnt_q   <= '0;
                            rst_n_q <= rst_n_nxt;
                            if (&rst_n_nxt) begin
                                state_q <= ST_RUN;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        // RUN: hold everything released.
                    end
                endcase
            end
        end
    end

    assign RST_N_O    = rst_n_q;
    assign READY_O    = ready_q;
    assign STATE_O    = state_q;
    assign BROWNOUT_O = brownout_q;

`ifdef POR_SEQ_BROWNOUT_CNT_EN
    logic [7:0] bcnt_q;

    // Counts on the same edge that raises BROWNOUT_O; only RST_I clears it.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)                               bcnt_q <= '0;
        else if (brownout_set && bcnt_q != 8'hFF) bcnt_q <= bcnt_q + 8'd1;
    end

    assign BROWNOUT_CNT_O = bcnt_q;
`endif
endmodule

// File: tb/tb_por_reset_sequencer.sv
module tb_por_reset_sequencer;
    localparam int SS = 2;
    localparam int ND = 4;
    localparam int FC = 16;
    localparam int SD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] por_n = 2'b00;
    logic       sw = 1'b0;
    logic [3:0] rst_n_o;
    logic       ready_o;
    logic [1:0] state_o;
    logic       brown_o;
`ifdef POR_SEQ_BROWNOUT_CNT_EN
    logic [7:0] bcnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    por_reset_sequencer dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .POR_N_I      (por_n),
        .SW_RST_REQ_I (sw),
        .RST_N_O      (rst_n_o),
        .READY_O      (ready_o),
        .STATE_O      (state_o),
        .BROWNOUT_O   (brown_o)
`ifdef POR_SEQ_BROWNOUT_CNT_EN
        ,
        .BROWNOUT_CNT_O (bcnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: tracks time since the sequence (re)started and
    // derives the outputs from the release schedule arithmetically.
    logic [SS-1:0] m_hist;
    bit            m_active;
    int            m_t;
    bit            m_brown;
    int            m_bcnt;

    task automatic model_reset();
        m_hist = '0; m_active = 0; m_t = 0; m_brown = 0; m_bcnt = 0;
    endtask

    task automatic model_step(input logic [1:0] p, input logic s);
        bit ok;
        ok = m_hist[SS-1];
        m_hist = {m_hist[SS-2:0], &p};
        m_brown = 0;
        if (!ok) begin
            m_brown  = m_active && (m_t >= FC);
            m_active = 0;
        end else if (!m_active) begin
            m_active = 1; m_t = 0;
        end else if (s && m_t >= FC) begin
            m_active = 0;
        end else if (s) begin
            m_t = 0;
        end else begin
            m_t++;
        end
        if (m_brown && m_bcnt < 255) m_bcnt++;
    endtask

    // {state, ready, brownout, rst_n}
    function automatic logic [7:0] model_out();
        int rel;
        logic [3:0] r;
        if (!m_active) return {2'd0, 1'b0, m_brown, 4'b0000};
        if (m_t < FC)  return {2'd1, 1'b0, m_brown, 4'b0000};
        rel = (m_t - FC) / SD + 1;
        if (rel > ND) rel = ND;
        r = 4'((1 << rel) - 1);
        return {(rel == ND) ? 2'd3 : 2'd2, rel == ND, m_brown, r};
    endfunction

    typedef struct {
        logic [1:0] por_n;
        logic       sw;
        int         n;
        logic [3:0] rst_n;
        logic       ready;
        logic [1:0] state;
        logic       brown;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[31];
        logic [1:0] drop_mask;
        int drop_left;
        int waited;
        bit abort;

        // Power-up release
        vecs[0]  = '{2'b11, 1'b0, 2,  4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{2'b11, 1'b0, 1,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[2]  = '{2'b11, 1'b0, 15, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[3]  = '{2'b11, 1'b0, 1,  4'b0001, 1'b0, 2'd2, 1'b0};
        vecs[4]  = '{2'b11, 1'b0, 7,  4'b0001, 1'b0, 2'd2, 1'b0};
        vecs[5]  = '{2'b11, 1'b0, 1,  4'b0011, 1'b0, 2'd2, 1'b0};
        vecs[6]  = '{2'b11, 1'b0, 8,  4'b0111, 1'b0, 2'd2, 1'b0};
        vecs[7]  = '{2'b11, 1'b0, 8,  4'b1111, 1'b1, 2'd3, 1'b0};
        // Brown-out in RUN: assertion 3 edges after the drop, one-cycle pulse
        vecs[8]  = '{2'b10, 1'b0, 2,  4'b1111, 1'b1, 2'd3, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 1,  4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[10] = '{2'b10, 1'b0, 1,  4'b0000, 1'b0, 2'd0, 1'b0};
        // Glitch inside the filter window restarts the filter from 0
        vecs[11] = '{2'b11, 1'b0, 3,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[12] = '{2'b11, 1'b0, 5,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[13] = '{2'b01, 1'b0, 3,  4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{2'b11, 1'b0, 2,  4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[15] = '{2'b11, 1'b0, 1,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[16] = '{2'b11, 1'b0, 15, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[17] = '{2'b11, 1'b0, 1,  4'b0001, 1'b0, 2'd2, 1'b0};
        // Collision in RELEASE: POR loss and software request together
        vecs[18] = '{2'b00, 1'b0, 2,  4'b0001, 1'b0, 2'd2, 1'b0};
        vecs[19] = '{2'b00, 1'b1, 1,  4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[20] = '{2'b00, 1'b0, 1,  4'b0000, 1'b0, 2'd0, 1'b0};
        // Software reset in RUN, then full repeat: ready 41 edges later
        vecs[21] = '{2'b11, 1'b0, 3,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[22] = '{2'b11, 1'b0, 40, 4'b1111, 1'b1, 2'd3, 1'b0};
        vecs[23] = '{2'b11, 1'b1, 1,  4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[24] = '{2'b11, 1'b0, 1,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[25] = '{2'b11, 1'b0, 39, 4'b0111, 1'b0, 2'd2, 1'b0};
        vecs[26] = '{2'b11, 1'b0, 1,  4'b1111, 1'b1, 2'd3, 1'b0};
        // Software request in ASSERT is ignored
        vecs[27] = '{2'b00, 1'b0, 3,  4'b0000, 1'b0, 2'd0, 1'b1};
        vecs[28] = '{2'b11, 1'b0, 2,  4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[29] = '{2'b11, 1'b1, 1,  4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[30] = '{2'b11, 1'b0, 16, 4'b0001, 1'b0, 2'd2, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {state_o, ready_o, brown_o, rst_n_o}, 8'h00);
`ifdef POR_SEQ_BROWNOUT_CNT_EN
        check("reset_bcnt", bcnt_o, 0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            por_n = vecs[i].por_n;
            sw    = vecs[i].sw;
            for (int j = 0; j < vecs[i].n; j++) begin
                @(posedge clk);
                #1 sw = 1'b0;
            end
            @(negedge clk);
            check($sformatf("vec%0d", i), {state_o, ready_o, brown_o, rst_n_o},
                  {vecs[i].state, vecs[i].ready, vecs[i].brown, vecs[i].rst_n});
        end
`ifdef POR_SEQ_BROWNOUT_CNT_EN
        check("bcnt_after_table", bcnt_o, 3);
`endif

        // Asynchronous reset mid-RELEASE, away from any clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {state_o, ready_o, brown_o, rst_n_o}, 8'h00);
`ifdef POR_SEQ_BROWNOUT_CNT_EN
        check("async_rst_bcnt", bcnt_o, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomised stimulus against the reference model
        drop_left = 0;
        drop_mask = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            check("rand_outputs", {state_o, ready_o, brown_o, rst_n_o}, model_out());
`ifdef POR_SEQ_BROWNOUT_CNT_EN
            check("rand_bcnt", bcnt_o, m_bcnt);
`endif
            if (drop_left == 0 && $urandom_range(0, 119) == 0) begin
                drop_left = $urandom_range(1, 6);
                drop_mask = 2'($urandom_range(0, 2));
            end
            if (drop_left > 0) begin
                por_n = drop_mask;
                drop_left--;
            end else begin
                por_n = 2'b11;
            end
            sw = ($urandom_range(0, 149) == 0);
            @(posedge clk);
            model_step(por_n, sw);
            @(negedge clk);
        end
        sw = 1'b0;

`ifdef POR_SEQ_BROWNOUT_CNT_EN
        // Drive 300 brown-outs from RELEASE; counter must saturate
        abort = 0;
        for (int b = 0; b < 300 && !abort; b++) begin
            por_n = 2'b11;
            waited = 0;
            while (state_o != 2'd2 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (state_o != 2'd2) begin
                check("sat_reach_release", state_o, 2);
                abort = 1;
            end
            por_n = 2'b00;
            repeat (3) @(negedge clk);
        end
        check("bcnt_saturated", bcnt_o, 255);
        #2 rst = 1'b1;
        #1;
        check("bcnt_cleared_by_rst", bcnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
`else
        abort = 0;
        waited = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
